scemi_pipe_arbiter: RTL
=======================

# scemi_pipe_arbiter

Shares one SceMi input/output pipe pair between `NUM_CLIENTS` hardware requesters. Round-robin, burst-limited arbitration tags each outgoing message with its client id. Responses returning on the output pipe are steered back to the owning client by that id. Sits between transactor logic and a single pipe proxy, so several transactors share one bound pipe pair and one host-side channel.

## Interface
- `NUM_CLIENTS`, 4, number of requesters (2..16)
- `ID_WIDTH`, 2, tag width; must satisfy 2^ID_WIDTH >= NUM_CLIENTS
- `DATA_WIDTH`, 32, payload bits per message
- `MAX_BURST`, 4, messages one client may send per grant (1..255)
- `MAX_OUTSTANDING`, 8, per-client cap on requests awaiting a response (1..255)

Ports:
- `CLK`  in  1  sole clock; all logic on posedge
- `RST`  in  1  synchronous, active-high reset
- `REQ_VALID`  in  NUM_CLIENTS  client i has a message
- `REQ_READY`  out  NUM_CLIENTS  client i message accepted this cycle
- `REQ_DATA`  in  NUM_CLIENTS*DATA_WIDTH  flattened payloads, client i at [i*DATA_WIDTH +: DATA_WIDTH]
- `PIPE_IN_VALID`  out  1  message toward the input pipe
- `PIPE_IN_READY`  in  1  input pipe accepts
- `PIPE_IN_DATA`  out  ID_WIDTH+DATA_WIDTH  {id, payload}
- `PIPE_OUT_VALID`  in  1  response from the output pipe
- `PIPE_OUT_READY`  out  1  response consumed
- `PIPE_OUT_DATA`  in  ID_WIDTH+DATA_WIDTH  {id, payload}
- `RSP_VALID`  out  NUM_CLIENTS  response for client i
- `RSP_READY`  in  NUM_CLIENTS  client i takes response
- `RSP_DATA`  out  DATA_WIDTH  response payload, shared by all clients
- `ERR_BAD_ID`  out  1  sticky flag: a response carried id >= NUM_CLIENTS

## Operation
- **Eligibility.** Client i is eligible when `REQ_VALID[i]` is high and `outstanding[i] < MAX_OUTSTANDING`.
- **FSM state IDLE.** If any client is eligible, grant the first eligible client scanning upward from `last+1` (modulo NUM_CLIENTS). Set `last` to that client, clear `burst`, and go to GRANT.
- **FSM state GRANT.** `REQ_READY[g]` is high when client g is eligible and the output register is free. A register is free when `!PIPE_IN_VALID || PIPE_IN_READY`. All other `REQ_READY` bits are 0.
- **Accept.** On each accept, load the output register with {g, payload}, increment `burst`, and increment `outstanding[g]`.
- **Leave GRANT.** Return to IDLE when any of these holds: `burst` reaches MAX_BURST on an accept; client g is not eligible; or `REQ_VALID[g]` drops.
- **Response steering.**
  - `RSP_VALID[id] = PIPE_OUT_VALID`; all other `RSP_VALID` bits are 0.
  - `RSP_DATA` is the payload field.
  - `PIPE_OUT_READY = RSP_READY[id]`.
  - On a handshake, decrement `outstanding[id]`.
- **Bad id.** If id >= NUM_CLIENTS: `PIPE_OUT_READY = 1`, no `RSP_VALID` is raised, the response is dropped, and `ERR_BAD_ID` is set. It clears only on reset.
- **Counter arithmetic.**
  - `outstanding` counters are 8 bits.
  - Issue and response for the same client in one cycle leave the count unchanged.
  - A response for a client with count 0 leaves the count at 0 and sets `ERR_BAD_ID`.

## Timing
- **Reset values.** `PIPE_IN_VALID`=0, `REQ_READY`=0, `RSP_VALID` follows the steering rule (0 while `PIPE_OUT_VALID`=0), `ERR_BAD_ID`=0. State=IDLE, `last`=NUM_CLIENTS-1 (so client 0 wins first), all counters 0.
- **Latency.**
  - Accept cycle to `PIPE_IN_VALID`: 1 cycle.
  - Request through IDLE: 2 cycles (IDLE arbitration is one bubble cycle per grant).
- **Throughput.** Inside a burst: one message per cycle while `PIPE_IN_READY` stays high.
- **Holding.** `PIPE_IN_DATA` is stable while `PIPE_IN_VALID && !PIPE_IN_READY`.
- **Response path.** Combinational, zero latency, no buffering.
- **Reset mid-burst.** Discards the output register and all outstanding counts. Host-side in-flight messages are the integrator's responsibility.

## Configuration
- **`SCEMI_PIPE_ARB_STATS_EN` defined.**
  - Adds output `STAT_GRANTS` (NUM_CLIENTS*16): per-client 16-bit saturating count of accepted messages, reset to 0.
  - Adds output `STAT_STALLS` (16): saturating count of cycles with `PIPE_IN_VALID && !PIPE_IN_READY`.
- **Macro undefined.** These ports and counters do not exist; all other behaviour is identical.

## Structure
- **Shared package `scemi_pipe_arb_pkg`:**
  - FSM state encoding (IDLE=0, GRANT=1)
  - `STAT_WIDTH`=16
  - `CNT_WIDTH`=8
  - a function computing the next round-robin winner from a request mask and `last`
- **Sub-module `scemi_rr_pick`.** Combinational masked round-robin priority encoder: inputs are mask and last; outputs are found and index. Instantiated once.

## Test plan
- **Single client.** Reset; `REQ_VALID[2]`=1 with data 0xA5, ready high → `PIPE_IN_DATA`={2,0xA5} two cycles after `REQ_VALID`; `outstanding[2]`=1.
- **Round-robin.** All four valid, MAX_BURST=4, `PIPE_IN_READY`=1 → ids 0,0,0,0,bubble,1,1,1,1,bubble,2…
- **Back-pressure.** `PIPE_IN_READY`=0 for 5 cycles mid-burst → data held constant, no `REQ_READY`, burst resumes without loss or duplication.
- **Outstanding cap.** MAX_OUTSTANDING=2, no responses → client 1 stops after 2 messages. One response id 1 → client 1 eligible again next IDLE.
- **Response steering.** Response {3,0x1234} with `RSP_READY[3]`=0 for 3 cycles → `RSP_VALID[3]` held, `PIPE_OUT_READY`=0; on ready, consumed and count decremented.
- **Bad id.** NUM_CLIENTS=3, response id 3 → dropped in 1 cycle, `ERR_BAD_ID`=1 until `RST`.

Source files
------------

// File: rtl/scemi_pipe_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the SceMi pipe arbiter.
package scemi_pipe_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int STAT_WIDTH  = 16;
    localparam int CNT_WIDTH   = 8;
    localparam int MAX_CLIENTS = 16;

    // Scans from last+1 upward (mod n); scanning the ring backwards lets the
    // nearest requester overwrite any farther one.
    function automatic logic [4:0] rr_next(
        input logic [MAX_CLIENTS-1:0] mask,
        input logic [3:0]             last,
        input int                     n
    );
        logic [4:0] pick;
        logic [3:0] idx4;
        int         idx;
        pick = '0;
        for (int k = MAX_CLIENTS; k >= 1; k--) begin
            if (k <= n) begin
                idx  = (int'(last) + k) % n;
                idx4 = idx[3:0];
                if (mask[idx4]) begin
                    pick = {1'b1, idx4};
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/scemi_rr_pick.sv
// Combinational masked round-robin priority encoder: first set mask bit after 'last'.
module scemi_rr_pick
    import scemi_pipe_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ID_WIDTH    = 2
) (
    input  logic [NUM_CLIENTS-1:0] mask,
    input  logic [ID_WIDTH-1:0]    last,
    output logic                   found,
    output logic [ID_WIDTH-1:0]    index
);

    logic [MAX_CLIENTS-1:0] mask_ext;
    logic [3:0]             last4;
    logic [4:0]             pick;

    always_comb begin
        mask_ext = MAX_CLIENTS'(mask);
        last4    = 4'(last);
        pick     = rr_next(mask_ext, last4, NUM_CLIENTS);
        found    = pick[4];
        index    = ID_WIDTH'(pick[3:0]);
    end

endmodule

// File: rtl/scemi_pipe_arbiter.sv
// Shares one SceMi input/output pipe pair among NUM_CLIENTS requesters with id tagging.
// Optional statistics counters are enabled by defining SCEMI_PIPE_ARB_STATS_EN.
module scemi_pipe_arbiter
    import scemi_pipe_arb_pkg::*;
#(
    parameter int NUM_CLIENTS     = 4,
    parameter int ID_WIDTH        = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_BURST       = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_CLIENTS-1:0]            REQ_VALID,
    output logic [NUM_CLIENTS-1:0]            REQ_READY,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] REQ_DATA,
    output logic                              PIPE_IN_VALID,
    input  logic                              PIPE_IN_READY,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]    PIPE_IN_DATA,
    input  logic                              PIPE_OUT_VALID,
    output logic                              PIPE_OUT_READY,
    input  logic [ID_WIDTH+DATA_WIDTH-1:0]    PIPE_OUT_DATA,
    output logic [NUM_CLIENTS-1:0]            RSP_VALID,
    input  logic [NUM_CLIENTS-1:0]            RSP_READY,
    output logic [DATA_WIDTH-1:0]             RSP_DATA,
    output logic                              ERR_BAD_ID,
`ifdef SCEMI_PIPE_ARB_STATS_EN
    output logic [NUM_CLIENTS*STAT_WIDTH-1:0] STAT_GRANTS,
    output logic [STAT_WIDTH-1:0]             STAT_STALLS,
`endif
    output logic                              DBG_STATE,
    output logic [NUM_CLIENTS*CNT_WIDTH-1:0]  DBG_OUTSTANDING
);

    // Every channel uses valid/ready: a transfer happens on a rising CLK edge
    // where both are high; valid never waits on ready, and the payload is held
    // stable while valid is high and ready is low.

    localparam logic [CNT_WIDTH-1:0] OUT_CAP    = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [7:0]           BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t                 state, state_next;
    logic [ID_WIDTH-1:0]        last, last_next;
    logic [7:0]                 burst, burst_next;
    logic [CNT_WIDTH-1:0]       outstanding [NUM_CLIENTS];

    logic [NUM_CLIENTS-1:0]     elig;
    logic [NUM_CLIENTS-1:0]     sel;
    logic [NUM_CLIENTS-1:0]     accept_vec;
    logic [NUM_CLIENTS-1:0]     rsp_hs;
    logic [NUM_CLIENTS-1:0]     cnt_zero;
    logic                       reg_free;
    logic                       g_elig;
    logic                       pick_found;
    logic [ID_WIDTH-1:0]        pick_idx;
    logic [DATA_WIDTH-1:0]      sel_data;

    logic                       in_valid;
    logic [ID_WIDTH+DATA_WIDTH-1:0] in_data;

    logic [ID_WIDTH-1:0]        rsp_id;
    logic                       bad_id;
    logic                       underflow;
    logic                       err;

    // Eligibility, grant decode and payload select
    always_comb begin
        elig     = '0;
        sel      = '0;
        cnt_zero = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            elig[i]     = REQ_VALID[i] && (outstanding[i] < OUT_CAP);
            sel[i]      = (last == ID_WIDTH'(i));
            cnt_zero[i] = (outstanding[i] == '0);
            if (sel[i]) begin
                sel_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        reg_free = !in_valid || PIPE_IN_READY;
        g_elig   = |(elig & sel);
    end

    scemi_rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ID_WIDTH    (ID_WIDTH)
    ) u_pick (
        .mask  (elig),
        .last  (last),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        state_next = state;
        last_next  = last;
        burst_next = burst;
        REQ_READY  = '0;
        accept_vec = '0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_GRANT;
                    last_next  = pick_idx;
                    burst_next = '0;
                end
            end
            ST_GRANT: begin
                if (!g_elig) begin
                    state_next = ST_IDLE;
                end else if (reg_free) begin
                    REQ_READY  = sel;
                    accept_vec = sel;
                    burst_next = burst + 8'd1;
                    if (burst == BURST_LAST) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // 'last' resets to the top client so client 0 wins the first arbitration
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            last  <= ID_WIDTH'(NUM_CLIENTS - 1);
            burst <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            burst <= burst_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            in_valid <= 1'b0;
            in_data  <= '0;
        end else if (|accept_vec) begin
            in_valid <= 1'b1;
            in_data  <= {last, sel_data};
        end else if (PIPE_IN_READY) begin
            in_valid <= 1'b0;
        end
    end

    assign PIPE_IN_VALID = in_valid;
    assign PIPE_IN_DATA  = in_data;

    // Response steering is purely combinational; bad ids are swallowed
    always_comb begin
        rsp_id         = PIPE_OUT_DATA[ID_WIDTH+DATA_WIDTH-1 -: ID_WIDTH];
        RSP_DATA       = PIPE_OUT_DATA[DATA_WIDTH-1:0];
        bad_id         = (32'(rsp_id) >= 32'(NUM_CLIENTS));
        RSP_VALID      = '0;
        rsp_hs         = '0;
        PIPE_OUT_READY = bad_id;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!bad_id && rsp_id == ID_WIDTH'(i)) begin
                RSP_VALID[i]   = PIPE_OUT_VALID;
                PIPE_OUT_READY = RSP_READY[i];
                rsp_hs[i]      = PIPE_OUT_VALID && RSP_READY[i];
            end
        end
        underflow = |(rsp_hs & cnt_zero);
    end

    // Simultaneous issue and response for one client cancel out
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (accept_vec[i] && !rsp_hs[i]) begin
                    outstanding[i] <= outstanding[i] + 1'b1;
                end else if (rsp_hs[i] && !accept_vec[i] && !cnt_zero[i]) begin
                    outstanding[i] <= outstanding[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err <= 1'b0;
        end else if ((PIPE_OUT_VALID && bad_id) || underflow) begin
            err <= 1'b1;
        end
    end

    assign ERR_BAD_ID = err;
    assign DBG_STATE  = state;

    always_comb begin
        DBG_OUTSTANDING = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            DBG_OUTSTANDING[i*CNT_WIDTH +: CNT_WIDTH] = outstanding[i];
        end
    end

`ifdef SCEMI_PIPE_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] grants [NUM_CLIENTS];
    logic [STAT_WIDTH-1:0] stalls;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                grants[i] <= '0;
            end
            stalls <= '0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (accept_vec[i] && grants[i] != '1) begin
                    grants[i] <= grants[i] + 1'b1;
                end
            end
            if (in_valid && !PIPE_IN_READY && stalls != '1) begin
                stalls <= stalls + 1'b1;
            end
        end
    end

    always_comb begin
        STAT_GRANTS = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            STAT_GRANTS[i*STAT_WIDTH +: STAT_WIDTH] = grants[i];
        end
    end

    assign STAT_STALLS = stalls;
`endif

endmodule
